// File: rtl/counter_pkg.sv
// Shared constants for step counters and other simple sequencers.
package counter_pkg;

    // Overflow policy selectors
    localparam int MODE_WRAP = 0;
    localparam int MODE_SAT  = 1;

    // Count direction encodings
    localparam logic DIR_UP   = 1'b0;
    localparam logic DIR_DOWN = 1'b1;

endpackage : counter_pkg

// File: rtl/step_counter_next_value.sv
// Combinational successor of a bounded count: steps the value up or down by
// STEP within 0..MAX_VAL, and flags when the step crosses a boundary.
// Arithmetic is carried in WIDTH+1 bits so no carry or borrow is lost.
module step_next_value
    import counter_pkg::*;
#(
    parameter int              WIDTH   = 16,
    parameter int unsigned     STEP    = 1,
    parameter longint unsigned MAX_VAL = (64'd1 << WIDTH) - 64'd1,
    parameter int              MODE    = MODE_WRAP
) (
    input  logic [WIDTH-1:0] count,
    input  logic             dir,
    output logic [WIDTH-1:0] next_count,
    output logic             crossed
);

    // Parameter sanity: reject illegal configurations at elaboration
    if (WIDTH < 2) begin : g_bad_width
        $fatal(1, "step_next_value: WIDTH must be at least 2");
    end
    if (STEP == 0) begin : g_bad_step_zero
        $fatal(1, "step_next_value: STEP must be nonzero");
    end
    if (longint'(STEP) > MAX_VAL) begin : g_bad_step_big
        $fatal(1, "step_next_value: STEP must not exceed MAX_VAL");
    end
    if (MAX_VAL >= (64'd1 << WIDTH)) begin : g_bad_max
        $fatal(1, "step_next_value: MAX_VAL must fit in WIDTH bits");
    end
    if (MODE != MODE_WRAP && MODE != MODE_SAT) begin : g_bad_mode
        $fatal(1, "step_next_value: MODE must be MODE_WRAP or MODE_SAT");
    end

    // Extended-width constants; MOD_E (= MAX_VAL+1) may equal 2**WIDTH
    localparam logic [WIDTH:0] MAX_E  = (WIDTH+1)'(MAX_VAL);
    localparam logic [WIDTH:0] STEP_E = (WIDTH+1)'(STEP);
    localparam logic [WIDTH:0] MOD_E  = MAX_E + 1'b1;

    // Upward overflow: wrap folds the excess back from zero, sat clamps
    function automatic logic [WIDTH:0] fold_up(input logic [WIDTH:0] sum);
        logic [WIDTH:0] r;
        if (MODE == MODE_SAT) begin
            r = MAX_E;
        end else begin
            r = sum - MOD_E;
        end
        return r;
    endfunction

    // Downward underflow: wrap borrows one modulus, sat clamps at zero
    function automatic logic [WIDTH:0] fold_down(input logic [WIDTH:0] cur);
        logic [WIDTH:0] r;
        if (MODE == MODE_SAT) begin
            r = '0;
        end else begin
            r = cur + MOD_E - STEP_E;
        end
        return r;
    endfunction

    logic [WIDTH:0] cur_e;
    logic [WIDTH:0] sum_e;
    logic [WIDTH:0] diff_e;
    logic [WIDTH:0] nxt_e;

    assign cur_e  = {1'b0, count};
    assign sum_e  = cur_e + STEP_E;
    assign diff_e = cur_e - STEP_E;

    // Select successor and crossing flag from direction and bounds
    always_comb begin
        nxt_e   = cur_e;
        crossed = 1'b0;
        if (dir == DIR_UP) begin
            if (sum_e > MAX_E) begin
                nxt_e   = fold_up(sum_e);
                crossed = 1'b1;
            end else begin
                nxt_e = sum_e;
            end
        end else begin
            if (cur_e < STEP_E) begin
                nxt_e   = fold_down(cur_e);
                crossed = 1'b1;
            end else begin
                nxt_e = diff_e;
            end
        end
    end

    // Successor always lies in 0..MAX_VAL, so the top bit is always clear
    assign next_count = nxt_e[WIDTH-1:0];

    logic unused_top;
    assign unused_top = nxt_e[WIDTH];

endmodule : step_next_value

// File: rtl/step_counter.sv
// Bounded step counter register: reset, clamped parallel load, and enabled
// up/down stepping with a registered boundary-crossing pulse. Used as a
// program counter, loop counter or generic timer.
module step_counter
    import counter_pkg::*;
#(
    parameter int              WIDTH   = 16,
    parameter int unsigned     STEP    = 1,
    parameter longint unsigned MAX_VAL = (64'd1 << WIDTH) - 64'd1,
    parameter int              MODE    = MODE_WRAP
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             dir,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] count,
    output logic             ovf,
    output logic             at_max,
    output logic             at_zero
);

    localparam logic [WIDTH:0] MAX_E = (WIDTH+1)'(MAX_VAL);

    // Out-of-range load values clamp to the top of the legal range
    function automatic logic [WIDTH-1:0] clamp_load(input logic [WIDTH-1:0] v);
        logic [WIDTH-1:0] r;
        if ({1'b0, v} > MAX_E) begin
            r = MAX_E[WIDTH-1:0];
        end else begin
            r = v;
        end
        return r;
    endfunction

    logic [WIDTH-1:0] count_p0;
    logic             ovf_p0;
    logic [WIDTH-1:0] step_nxt;
    logic             step_crossed;

    step_next_value #(
        .WIDTH   (WIDTH),
        .STEP    (STEP),
        .MAX_VAL (MAX_VAL),
        .MODE    (MODE)
    ) u_next (
        .count      (count_p0),
        .dir        (dir),
        .next_count (step_nxt),
        .crossed    (step_crossed)
    );

    // ---- stage p0: count/ovf register, priority rst > load > en > hold ----
    always_ff @(posedge clk) begin
        if (rst) begin
            count_p0 <= '0;
            ovf_p0   <= 1'b0;
        end else if (load) begin
            count_p0 <= clamp_load(load_val);
            ovf_p0   <= 1'b0;
        end else if (en) begin
            count_p0 <= step_nxt;
            ovf_p0   <= step_crossed;
        end else begin
            ovf_p0   <= 1'b0;
        end
    end

    assign count   = count_p0;
    assign ovf     = ovf_p0;
    assign at_max  = ({1'b0, count_p0} == MAX_E);
    assign at_zero = (count_p0 == '0);

endmodule : step_counter

// File: tb/tb_step_counter.sv
// Directed bench for step_counter across four configurations.
module tb_step_counter;
    import counter_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // A: W4, MAX 9, STEP 1, WRAP
    logic       a_rst, a_en, a_dir, a_load, a_ovf, a_max, a_zero;
    logic [3:0] a_lv, a_cnt;
    // B: W4, MAX 9, STEP 1, SAT
    logic       b_rst, b_en, b_dir, b_load, b_ovf, b_max, b_zero;
    logic [3:0] b_lv, b_cnt;
    // C: W4, MAX 9, STEP 3, WRAP
    logic       c_rst, c_en, c_dir, c_load, c_ovf, c_max, c_zero;
    logic [3:0] c_lv, c_cnt;
    // D: defaults (W16, STEP 1, MAX 0xFFFF, WRAP)
    logic        d_rst, d_en, d_dir, d_load, d_ovf, d_max, d_zero;
    logic [15:0] d_lv, d_cnt;

    step_counter #(.WIDTH(4), .STEP(1), .MAX_VAL(9), .MODE(MODE_WRAP)) dut_a (
        .clk(clk), .rst(a_rst), .en(a_en), .dir(a_dir), .load(a_load),
        .load_val(a_lv), .count(a_cnt), .ovf(a_ovf), .at_max(a_max), .at_zero(a_zero));

    step_counter #(.WIDTH(4), .STEP(1), .MAX_VAL(9), .MODE(MODE_SAT)) dut_b (
        .clk(clk), .rst(b_rst), .en(b_en), .dir(b_dir), .load(b_load),
        .load_val(b_lv), .count(b_cnt), .ovf(b_ovf), .at_max(b_max), .at_zero(b_zero));

    step_counter #(.WIDTH(4), .STEP(3), .MAX_VAL(9), .MODE(MODE_WRAP)) dut_c (
        .clk(clk), .rst(c_rst), .en(c_en), .dir(c_dir), .load(c_load),
        .load_val(c_lv), .count(c_cnt), .ovf(c_ovf), .at_max(c_max), .at_zero(c_zero));

    step_counter dut_d (
        .clk(clk), .rst(d_rst), .en(d_en), .dir(d_dir), .load(d_load),
        .load_val(d_lv), .count(d_cnt), .ovf(d_ovf), .at_max(d_max), .at_zero(d_zero));

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one clock and settle away from the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    int exp_up[10] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 0};

    initial begin
        a_rst = 1; a_en = 0; a_dir = 0; a_load = 0; a_lv = 0;
        b_rst = 1; b_en = 0; b_dir = 0; b_load = 0; b_lv = 0;
        c_rst = 1; c_en = 0; c_dir = 0; c_load = 0; c_lv = 0;
        d_rst = 1; d_en = 0; d_dir = 0; d_load = 0; d_lv = 0;
        tick();
        check("rst_a_cnt", a_cnt, 0);
        check("rst_a_ovf", a_ovf, 0);
        check("rst_a_zero", a_zero, 1);
        check("rst_a_max", a_max, 0);
        check("rst_d_cnt", d_cnt, 0);
        a_rst = 0; b_rst = 0; c_rst = 0; d_rst = 0;

        // 1: wrap up through 9 -> 0
        a_en = 1;
        for (int i = 0; i < 10; i++) begin
            tick();
            check($sformatf("t1_cnt_%0d", i), a_cnt, exp_up[i]);
            check($sformatf("t1_ovf_%0d", i), a_ovf, (i == 9) ? 1 : 0);
            check($sformatf("t1_max_%0d", i), a_max, (i == 8) ? 1 : 0);
        end
        a_en = 0;

        // 2: saturate up from 8, then step down
        b_load = 1; b_lv = 8;
        tick();
        check("t2_load8", b_cnt, 8);
        b_load = 0; b_en = 1;
        tick(); check("t2_c0", b_cnt, 9); check("t2_o0", b_ovf, 0);
        tick(); check("t2_c1", b_cnt, 9); check("t2_o1", b_ovf, 1);
        tick(); check("t2_c2", b_cnt, 9); check("t2_o2", b_ovf, 1);
        check("t2_max", b_max, 1);
        b_dir = 1;
        tick(); check("t2_dn", b_cnt, 8); check("t2_dn_ovf", b_ovf, 0);
        // saturate at zero while counting down
        b_en = 0; b_rst = 1;
        tick();
        b_rst = 0; b_en = 1;
        tick(); check("t2_z_cnt", b_cnt, 0); check("t2_z_ovf", b_ovf, 1);
        b_en = 0;
        tick(); check("t2_hold_ovf", b_ovf, 0);

        // 3: STEP=3 wrap both ways
        c_load = 1; c_lv = 8;
        tick();
        c_load = 0; c_en = 1; c_dir = 0;
        tick(); check("t3_up_cnt", c_cnt, 1); check("t3_up_ovf", c_ovf, 1);
        c_dir = 1;
        tick(); check("t3_dn_cnt", c_cnt, 8); check("t3_dn_ovf", c_ovf, 1);
        c_en = 0; c_load = 1; c_lv = 3;
        tick();
        c_load = 0; c_en = 1;
        tick(); check("t3_dn0_cnt", c_cnt, 0); check("t3_dn0_ovf", c_ovf, 0);
        check("t3_dn0_zero", c_zero, 1);

        // 4: load beats en, out-of-range clamps
        c_dir = 0; c_en = 1; c_load = 1; c_lv = 12;
        tick(); check("t4_clamp", c_cnt, 9); check("t4_clamp_ovf", c_ovf, 0);
        check("t4_clamp_max", c_max, 1);
        c_lv = 5;
        tick(); check("t4_load5", c_cnt, 5);
        c_load = 0; c_en = 0;

        // 5: reset beats load mid-sequence
        a_load = 1; a_lv = 7;
        tick();
        a_load = 0; a_en = 1;
        tick(); check("t5_pre", a_cnt, 8);
        a_rst = 1; a_load = 1; a_lv = 3;
        tick();
        check("t5_rst_cnt", a_cnt, 0); check("t5_rst_ovf", a_ovf, 0);
        check("t5_rst_zero", a_zero, 1);
        a_rst = 0; a_load = 0;
        tick(); check("t5_after", a_cnt, 1);
        a_en = 0;

        // 6: default 16-bit configuration
        d_load = 1; d_lv = 16'h7FFF;
        tick();
        d_load = 0; d_en = 1;
        tick(); check("t6_mid", d_cnt, 16'h8000); check("t6_mid_ovf", d_ovf, 0);
        d_en = 0; d_load = 1; d_lv = 16'hFFFF;
        tick(); check("t6_max", d_max, 1);
        d_load = 0; d_en = 1;
        tick(); check("t6_wrap", d_cnt, 0); check("t6_wrap_ovf", d_ovf, 1);
        check("t6_wrap_zero", d_zero, 1);
        d_en = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check($sformatf("t6_hold_%0d", i), d_cnt, 0);
            check($sformatf("t6_hold_ovf_%0d", i), d_ovf, 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_step_counter

// File: doc/step_counter.md
Name: step_counter

Overview:
Parametrised sequential counter register: the clocked successor of the 16-bit combinational incrementer.
- Holds a WIDTH-bit count.
- Adds or subtracts a compile-time STEP each enabled cycle.
- Supports parallel load, a programmable modulus (MAX_VAL), and wrap or saturate overflow policy.
- Used as program counter / loop counter in the CPU datapath and as a generic timer.

Parameters:
WIDTH, 16, count width in bits (>= 2)
STEP, 1, increment/decrement amount; constraint 1 <= STEP <= MAX_VAL
MAX_VAL, 2**WIDTH-1, highest legal count; range is 0..MAX_VAL
MODE, MODE_WRAP, overflow policy: MODE_WRAP (modulo MAX_VAL+1) or MODE_SAT (clamp)

Ports:
clk  input  1  single clock; all state updates on rising edge
rst  input  1  synchronous, active-high reset
en  input  1  count enable
dir  input  1  0 = count up, 1 = count down
load  input  1  parallel load strobe
load_val  input  WIDTH  value to load
count  output  WIDTH  current count (registered)
ovf  output  1  registered one-cycle pulse: last update crossed a boundary (wrapped or saturated)
at_max  output  1  combinational: count == MAX_VAL
at_zero  output  1  combinational: count == 0

Behaviour:
- Priority per rising edge: rst > load > en > hold.
- rst=1: count <= 0, ovf <= 0. Applies regardless of load/en; a reset mid-sequence discards the count.
- load=1 (rst=0):
  - count <= min(load_val, MAX_VAL); out-of-range load clamps to MAX_VAL.
  - ovf <= 0.
  - en is ignored that cycle.
- en=1, load=0, rst=0: compute the next value in WIDTH+1 bits, so there is no silent truncation.
  - Up, count+STEP <= MAX_VAL: count <= count+STEP, ovf <= 0.
  - Up, count+STEP > MAX_VAL:
    - WRAP: count <= count+STEP-(MAX_VAL+1).
    - SAT: count <= MAX_VAL.
    - ovf <= 1.
  - Down, count >= STEP: count <= count-STEP, ovf <= 0.
  - Down, count < STEP:
    - WRAP: count <= count+(MAX_VAL+1)-STEP.
    - SAT: count <= 0.
    - ovf <= 1.
- SAT mode: ovf pulses on every enabled cycle that attempts to pass the boundary, including while already at the limit.
- en=0 (no rst/load): count holds, ovf <= 0.
- Latency: one cycle from en/load/rst to count. ovf is aligned with the count value it describes.
- at_max and at_zero decode the registered count. They carry no extra latency and are valid during reset (at_zero=1 after reset).
- Special case MAX_VAL = 2**WIDTH-1, STEP=1, up, WRAP: behaviour equals natural WIDTH-bit increment (0xFFFF -> 0x0000 for WIDTH=16).
- Elaboration check: STEP = 0, STEP > MAX_VAL or MAX_VAL >= 2**WIDTH causes a $fatal.

Decomposition:
- Shared package counter_pkg:
  - MODE_WRAP / MODE_SAT localparam constants.
  - Direction constants DIR_UP=0 / DIR_DOWN=1.
- One natural combinational sub-module, step_next_value.
  - Inputs: count, dir. Parameters: WIDTH, STEP, MAX_VAL, MODE.
  - Outputs: next count and crossed flag.
  - Reusable by other sequencers; the top contains only priority muxing and registers.

Test Plan:
1. WIDTH=4, MAX_VAL=9, STEP=1, WRAP; reset, en=1 up for 10 cycles -> count 1..9 then 0; ovf=1 only on the 9->0 cycle; at_max=1 while count=9.
2. Same config, SAT, up from 8 for 3 cycles -> 9, 9, 9; ovf = 0, 1, 1; then dir=1 for one cycle -> 8, ovf=0.
3. WIDTH=4, MAX_VAL=9, STEP=3, WRAP:
   - load 8 then en up -> 1 with ovf=1.
   - dir=1 from 1 -> 8 with ovf=1.
   - dir=1 from 3 -> 0 with ovf=0.
4. Load priority:
   - load=1, load_val=12, en=1 -> count=9 (clamped), ovf=0.
   - load=1, load_val=5 -> 5.
5. Reset mid-operation: count at 7 with en=1, assert rst together with load=1, load_val=3 -> count=0, ovf=0, at_zero=1; deassert and en=1 -> 1.
6. Default params (WIDTH=16, STEP=1, WRAP): load 0x7FFF, en up -> 0x8000. Load 0xFFFF, en up -> 0x0000 with ovf=1. en=0 for 5 cycles -> count holds, ovf=0.
